// File: rtl/hbridge_drive.sv
// -----------------------------------------------------------------------------
// hbridge_drive
//
// Output stage between the rover's turn/drive command logic and the motor
// H-bridge pins. Converts a 4-bit direction pattern plus an 8-bit duty into
// IN1..IN4 and a shared PWM enable for both motors. It also:
//   - coasts the bridge (all IN=0, EN=0) for DEAD_CYCLES on a pattern change,
//   - latches a sticky fault on any shoot-through pattern (a leg pair of 11),
//   - stops the rover if no command arrives within WDOG_CYCLES.
//
// Ports
//   clock         in   1  system clock
//   reset         in   1  synchronous reset, active-low (0 = reset)
//   cmd           in   4  [3:2] motor A IN1/IN2, [1:0] motor B IN3/IN4
//   cmd_valid     in   1  cmd is sampled on a rising edge when 1
//   duty          in   8  PWM duty 0..255, latched at the start of a PWM period
//   hbridge_in    out  4  H-bridge IN1..IN4
//   en_a          out  1  PWM enable, motor A
//   en_b          out  1  PWM enable, motor B
//   busy          out  1  1 while coasting through dead time
//   fault         out  1  sticky illegal-pattern flag (cleared only by reset)
//   wdog_timeout  out  1  one-cycle pulse when the watchdog forces a stop
//
// All outputs are registered and reflect the state entered at the last edge.
// -----------------------------------------------------------------------------
module hbridge_drive #(
    parameter logic [27:0] DEAD_CYCLES = 28'd50000,
    parameter logic [27:0] WDOG_CYCLES = 28'd25000000,
    parameter logic [7:0]  PWM_DIV     = 8'd195
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    input  logic [7:0] duty,
    output logic [3:0] hbridge_in,
    output logic       en_a,
    output logic       en_b,
    output logic       busy,
    output logic       fault,
    output logic       wdog_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic [27:0] dead_q, dead_d;
    logic [27:0] wdog_q, wdog_d;
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  duty_lat_q, duty_lat_d;

    logic [3:0]  hb_q, hb_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic        wdt_q, wdt_d;

    logic        illegal;
    logic        legal;
    logic        step_tick;
    logic        wdog_expire;
    logic        dead_done;

    // -------------------------------------------------------------------------
    // Command qualification and free-running PWM timebase
    // -------------------------------------------------------------------------
    always_comb begin
        // A leg pair of 11 would short that half-bridge (shoot-through).
        illegal    = cmd_valid && ((cmd[3:2] == 2'b11) || (cmd[1:0] == 2'b11));
        legal      = cmd_valid && !illegal;

        step_tick  = (pre_q == PWM_DIV - 8'd1);
        pre_d      = step_tick ? 8'd0 : pre_q + 8'd1;
        step_d     = step_tick ? step_q + 8'd1 : step_q;
        // Duty only changes as the step counter wraps to 0, so a period is
        // never cut short or stretched by a mid-period duty update.
        duty_lat_d = (step_tick && (step_q == 8'hFF)) ? duty : duty_lat_q;
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: illegal cmd > legal cmd > watchdog > dead time.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        target_d    = target_q;
        dead_d      = dead_q;
        wdog_d      = wdog_q;
        wdt_d       = 1'b0;
        wdog_expire = (wdog_q == WDOG_CYCLES - 28'd1);
        dead_done   = (dead_q == DEAD_CYCLES - 28'd1);

        if (illegal) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wdog_d = 28'd0;
                    if (legal && (cmd != 4'b0000)) begin
                        state_d  = ST_RUN;
                        target_d = cmd;
                    end
                end

                ST_RUN: begin
                    if (legal) begin
                        wdog_d = 28'd0;
                        if (cmd == 4'b0000) begin
                            state_d = ST_IDLE;
                        end else if (cmd != target_q) begin
                            state_d  = ST_DEAD;
                            target_d = cmd;
                            dead_d   = 28'd0;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_IDLE;
                        wdog_d  = 28'd0;
                        wdt_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 28'd1;
                    end
                end

                ST_DEAD: begin
                    if (legal) begin
                        wdog_d = 28'd0;
                        if (cmd == 4'b0000) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Any new nonzero pattern re-arms the full coast.
                            target_d = cmd;
                            dead_d   = 28'd0;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_IDLE;
                        wdog_d  = 28'd0;
                        wdt_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 28'd1;
                        if (dead_done) begin
                            state_d = ST_RUN;
                        end else begin
                            dead_d = dead_q + 28'd1;
                        end
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are derived from the state being entered so they register
        // together with it: a cmd accepted at an edge is visible right after it.
        hb_d    = (state_d == ST_RUN) ? target_d : 4'b0000;
        en_d    = (state_d == ST_RUN) && (step_d < duty_lat_d);
        busy_d  = (state_d == ST_DEAD);
        fault_d = (state_d == ST_FAULT);
    end

    // -------------------------------------------------------------------------
    // Registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q    <= ST_IDLE;
            target_q   <= 4'b0000;
            dead_q     <= 28'd0;
            wdog_q     <= 28'd0;
            pre_q      <= 8'd0;
            step_q     <= 8'd0;
            duty_lat_q <= 8'd0;
            hb_q       <= 4'b0000;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            wdt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            dead_q     <= dead_d;
            wdog_q     <= wdog_d;
            pre_q      <= pre_d;
            step_q     <= step_d;
            duty_lat_q <= duty_lat_d;
            hb_q       <= hb_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            wdt_q      <= wdt_d;
        end
    end

    assign hbridge_in   = hb_q;
    assign en_a         = en_q;
    assign en_b         = en_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
    assign wdog_timeout = wdt_q;

endmodule

// File: tb/tb_hbridge_drive.sv
// -----------------------------------------------------------------------------
// tb_hbridge_drive
//
// Bench for hbridge_drive with DEAD_CYCLES=4, WDOG_CYCLES=20, PWM_DIV=1.
// The reference model tracks the rover's mode, the remaining coast cycles,
// the number of cycles since the last refresh, and the PWM position derived
// from the absolute cycle count since reset.
// -----------------------------------------------------------------------------
module tb_hbridge_drive;

    localparam int DEAD = 4;
    localparam int WDOG = 20;
    localparam int PDIV = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd = 4'b0000;
    logic       cmd_valid = 1'b0;
    logic [7:0] duty = 8'd0;
    logic [3:0] hbridge_in;
    logic       en_a, en_b, busy, fault, wdog_timeout;

    hbridge_drive #(
        .DEAD_CYCLES(28'd4),
        .WDOG_CYCLES(28'd20),
        .PWM_DIV    (8'd1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .duty        (duty),
        .hbridge_in  (hbridge_in),
        .en_a        (en_a),
        .en_b        (en_b),
        .busy        (busy),
        .fault       (fault),
        .wdog_timeout(wdog_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_en   = 0;
    int cnt_busy = 0;
    int cnt_to   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef enum {MD_IDLE, MD_RUN, MD_COAST, MD_FAULT} mode_t;
    mode_t      m_mode   = MD_IDLE;
    logic [3:0] m_target = 4'b0000;
    int         m_coast  = 0;   // coast cycles still to go
    int         m_quiet  = 0;   // cycles in RUN/COAST since last refresh
    int         m_ticks  = 0;   // clock edges since reset
    int         m_duty   = 0;
    bit         m_pulse  = 1'b0;

    task automatic model_edge(input logic r, input logic [3:0] c, input logic v, input logic [7:0] d);
        bit bad;
        bit good;
        m_pulse = 1'b0;
        if (!r) begin
            m_mode = MD_IDLE; m_target = 4'b0000; m_coast = 0;
            m_quiet = 0; m_ticks = 0; m_duty = 0;
            return;
        end
        m_ticks++;
        if ((m_ticks % PDIV == 0) && ((m_ticks / PDIV) % 256 == 0)) m_duty = int'(d);

        bad  = v && ((c[3:2] == 2'b11) || (c[1:0] == 2'b11));
        good = v && !bad;
        if (bad) begin
            m_mode = MD_FAULT;
        end else if (m_mode == MD_FAULT) begin
            // stays until reset
        end else if (good) begin
            m_quiet = 0;
            case (m_mode)
                MD_IDLE: if (c != 4'b0000) begin m_mode = MD_RUN; m_target = c; end
                MD_RUN: begin
                    if (c == 4'b0000) m_mode = MD_IDLE;
                    else if (c != m_target) begin m_mode = MD_COAST; m_target = c; m_coast = DEAD; end
                end
                MD_COAST: begin
                    if (c == 4'b0000) m_mode = MD_IDLE;
                    else begin m_target = c; m_coast = DEAD; end
                end
                default: ;
            endcase
        end else if (m_mode == MD_RUN || m_mode == MD_COAST) begin
            m_quiet++;
            if (m_quiet == WDOG) begin
                m_mode = MD_IDLE; m_quiet = 0; m_pulse = 1'b1;
            end else if (m_mode == MD_COAST) begin
                m_coast--;
                if (m_coast == 0) m_mode = MD_RUN;
            end
        end
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic step(input logic r, input logic [3:0] c, input logic v, input logic [7:0] d);
        int  pwm_step;
        bit  exp_en;
        @(negedge clock);
        reset = r; cmd = c; cmd_valid = v; duty = d;
        @(posedge clock);
        model_edge(r, c, v, d);
        #1;
        pwm_step = (m_ticks / PDIV) % 256;
        exp_en   = (m_mode == MD_RUN) && (pwm_step < m_duty);
        check("hbridge_in", 32'(hbridge_in), 32'((m_mode == MD_RUN) ? m_target : 4'b0000));
        check("en_a", 32'(en_a), 32'(exp_en));
        check("en_b", 32'(en_b), 32'(exp_en));
        check("busy", 32'(busy), 32'(m_mode == MD_COAST));
        check("fault", 32'(fault), 32'(m_mode == MD_FAULT));
        check("wdog_timeout", 32'(wdog_timeout), 32'(m_pulse));
        cnt_en   += int'(en_a);
        cnt_busy += int'(busy);
        cnt_to   += int'(wdog_timeout);
    endtask

    // n cycles; a valid cmd every `refresh` cycles (0 = never valid)
    task automatic cycles(input int n, input logic [3:0] c, input int refresh, input logic [7:0] d);
        for (int i = 0; i < n; i++)
            step(1'b1, c, (refresh > 0) && (i % refresh == 0), d);
    endtask

    task automatic clr_counts();
        cnt_en = 0; cnt_busy = 0; cnt_to = 0;
    endtask

    logic [3:0] pats [0:8] = '{4'h0, 4'h5, 4'hA, 4'h4, 4'h1, 4'h8, 4'h2, 4'h6, 4'h9};

    initial begin
        logic [3:0] rc;
        logic [7:0] rd;
        logic       rv;
        logic       rr;

        // Reset state
        step(1'b0, 4'b0000, 1'b0, 8'd0);
        step(1'b0, 4'b0000, 1'b0, 8'd0);
        check("reset_hb", 32'(hbridge_in), 32'(0));
        check("reset_fault", 32'(fault), 32'(0));

        // 1: start right, duty 128 -> 128 of 256 steps high
        step(1'b1, 4'b0101, 1'b1, 8'd128);
        check("start_hb", 32'(hbridge_in), 32'(4'b0101));
        cycles(300, 4'b0101, 10, 8'd128);
        clr_counts();
        cycles(256, 4'b0101, 10, 8'd128);
        check("duty128_count", 32'(cnt_en), 32'(128));

        // 2: pattern change -> exactly 4 coast cycles
        clr_counts();
        step(1'b1, 4'b1010, 1'b1, 8'd128);
        cycles(10, 4'b1010, 0, 8'd128);
        check("dead_len", 32'(cnt_busy), 32'(DEAD));
        check("after_dead_hb", 32'(hbridge_in), 32'(4'b1010));

        // 3: new pattern mid-coast restarts the dead time
        step(1'b1, 4'b0101, 1'b1, 8'd128);
        cycles(2, 4'b0101, 0, 8'd128);
        clr_counts();
        step(1'b1, 4'b0101, 1'b1, 8'd128);
        cycles(10, 4'b0101, 0, 8'd128);
        check("restart_dead_len", 32'(cnt_busy), 32'(DEAD));
        check("restart_hb", 32'(hbridge_in), 32'(4'b0101));

        // 4: shoot-through pattern -> sticky fault until reset
        step(1'b1, 4'b1100, 1'b1, 8'd128);
        check("fault_set", 32'(fault), 32'(1));
        cycles(6, 4'b0101, 1, 8'd128);
        check("fault_sticky", 32'(fault), 32'(1));
        check("fault_hb", 32'(hbridge_in), 32'(0));
        step(1'b0, 4'b0000, 1'b0, 8'd128);
        check("fault_cleared", 32'(fault), 32'(0));

        // 5: watchdog stop, then refreshed run with no timeout
        step(1'b1, 4'b0101, 1'b1, 8'd128);
        clr_counts();
        cycles(25, 4'b0101, 0, 8'd128);
        check("wdog_pulses", 32'(cnt_to), 32'(1));
        check("wdog_hb", 32'(hbridge_in), 32'(0));
        step(1'b1, 4'b0101, 1'b1, 8'd128);
        clr_counts();
        cycles(60, 4'b0101, 10, 8'd128);
        check("refresh_no_timeout", 32'(cnt_to), 32'(0));
        check("refresh_hb", 32'(hbridge_in), 32'(4'b0101));

        // 6: duty extremes; mid-period changes are covered by the model
        cycles(300, 4'b0101, 10, 8'd0);
        clr_counts();
        cycles(256, 4'b0101, 10, 8'd0);
        check("duty0_count", 32'(cnt_en), 32'(0));
        cycles(300, 4'b0101, 10, 8'd255);
        clr_counts();
        cycles(256, 4'b0101, 10, 8'd255);
        check("duty255_count", 32'(cnt_en), 32'(255));
        cycles(100, 4'b0101, 10, 8'd30);
        cycles(300, 4'b0101, 10, 8'd200);

        // Randomized traffic
        rd = 8'd100;
        for (int i = 0; i < 4000; i++) begin
            rr = (m_mode == MD_FAULT) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 299) != 0);
            rv = ($urandom_range(0, 3) == 0);
            rc = 4'($urandom_range(0, 15));
            if (((rc[3:2] == 2'b11) || (rc[1:0] == 2'b11)) && ($urandom_range(0, 9) != 0))
                rc = pats[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) == 0) rd = 8'($urandom_range(0, 255));
            step(rr, rc, rv, rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
